chronometer_control: RTL and testbench

//  Front-end controller for the chronometer: turns two raw push-button inputs
//  (start/stop, clear) into the chronometer's resetChronometer and

---
 rtl/chronometer_control.sv | 100 ++++++++++
 tb/tb_chronometer_control.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chronometer_control.sv
`default_nettype none
// ============================================================================
// Module     : chronometer_control
// Description: Debounced start/stop and clear buttons driving a 4-state Moore
//              FSM that produces the chronometer's reset/enable control levels.
// Revision   : 1.0 - initial release
// ============================================================================
module chronometer_control #(
    parameter int FREQ_IN     = 10000,
    parameter int DEBOUNCE_MS = 20
) (
    input  logic clk,
    input  logic resetControl,
    input  logic btnStartStop,
    input  logic btnClear,
    output logic resetChronometer,
    output logic enableTimmerCounter,
    output logic paused
);

    localparam int DEBOUNCE_CYCLES = FREQ_IN * DEBOUNCE_MS / 1000;
    localparam int c_CNT_W         = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] c_IDLE    = 2'b00;
    localparam logic [1:0] c_RUNNING = 2'b01;
    localparam logic [1:0] c_PAUSED  = 2'b10;
    localparam logic [1:0] c_CLEAR   = 2'b11;

    // Bit 0 is start/stop, bit 1 is clear
    logic [1:0] w_btnRaw;
    logic [1:0] w_pulse;

    assign w_btnRaw = {btnClear, btnStartStop};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic               r_sync1;
        logic               r_sync2;
        logic               r_stable;
        logic               r_stableQ;
        logic [c_CNT_W-1:0] r_count;

        always_ff @(posedge clk) begin
            if (resetControl) begin
                r_sync1   <= 1'b0;
                r_sync2   <= 1'b0;
                r_stable  <= 1'b0;
                r_stableQ <= 1'b0;
                r_count   <= '0;
            end else begin
                r_sync1   <= w_btnRaw[gi];
                r_sync2   <= r_sync1;
                r_stableQ <= r_stable;
                // Any bounce back to the accepted level restarts the count
                if (r_sync2 == r_stable) begin
                    r_count <= '0;
                end else if (r_count == c_CNT_LAST) begin
                    r_stable <= r_sync2;
                    r_count  <= '0;
                end else begin
                    r_count <= r_count + c_CNT_W'(1);
                end
            end
        end

        assign w_pulse[gi] = r_stable & ~r_stableQ;
    end

    logic [1:0] r_state;
    logic [1:0] w_stateNext;

    always_ff @(posedge clk) begin
        if (resetControl) begin
            r_state <= c_CLEAR;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Clear wins over a simultaneous start/stop pulse
    always_comb begin
        w_stateNext = r_state;
        if (w_pulse[1]) begin
            w_stateNext = c_CLEAR;
        end else begin
            case (r_state)
                c_IDLE:    if (w_pulse[0]) w_stateNext = c_RUNNING;
                c_RUNNING: if (w_pulse[0]) w_stateNext = c_PAUSED;
                c_PAUSED:  if (w_pulse[0]) w_stateNext = c_RUNNING;
                c_CLEAR:   w_stateNext = c_IDLE;
            endcase
        end
    end

    assign resetChronometer    = (r_state == c_CLEAR);
    assign enableTimmerCounter = (r_state == c_RUNNING);
    assign paused              = (r_state == c_PAUSED);

endmodule
`default_nettype wire

// File: tb/tb_chronometer_control.sv
`default_nettype none
// ============================================================================
// Module     : tb_chronometer_control
// Description: Directed self-checking bench for chronometer_control.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_chronometer_control;

    logic clk = 1'b0;
    logic resetControl = 1'b1;
    logic btnStartStop = 1'b0;
    logic btnClear = 1'b0;
    logic resetChronometer;
    logic enableTimmerCounter;
    logic paused;

    int nChecks = 0;
    int nFails  = 0;

    chronometer_control #(
        .FREQ_IN    (10000),
        .DEBOUNCE_MS(1)
    ) dut (
        .clk                (clk),
        .resetControl       (resetControl),
        .btnStartStop       (btnStartStop),
        .btnClear           (btnClear),
        .resetChronometer   (resetChronometer),
        .enableTimmerCounter(enableTimmerCounter),
        .paused             (paused)
    );

    always #5 clk = ~clk;

    // Outputs are packed as {resetChronometer, enableTimmerCounter, paused}
    logic [2:0] w_outs;
    assign w_outs = {resetChronometer, enableTimmerCounter, paused};

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            nChecks++;
            if (w_outs !== 3'b100) begin
                nFails++;
                $display("FAIL reset_held[%0d]: got %b expected 100", i, w_outs);
            end
        end
        resetControl = 1'b0;
        nChecks++;
        if (w_outs !== 3'b100) begin
            nFails++;
            $display("FAIL reset_release_cycle: got %b expected 100", w_outs);
        end
        tick();
        nChecks++;
        if (w_outs !== 3'b000) begin
            nFails++;
            $display("FAIL reset_idle: got %b expected 000", w_outs);
        end
    endtask

    task automatic test_start();
        btnStartStop = 1'b1;
        tick(12);
        nChecks++;
        if (w_outs !== 3'b000) begin
            nFails++;
            $display("FAIL start_edge11: got %b expected 000", w_outs);
        end
        tick();
        nChecks++;
        if (w_outs !== 3'b010) begin
            nFails++;
            $display("FAIL start_edge12: got %b expected 010", w_outs);
        end
        tick(17);
        btnStartStop = 1'b0;
        tick(30);
        nChecks++;
        if (w_outs !== 3'b010) begin
            nFails++;
            $display("FAIL start_no_toggle: got %b expected 010", w_outs);
        end
    endtask

    task automatic test_bounce();
        btnStartStop = 1'b1; tick(9);
        btnStartStop = 1'b0; tick(2);
        btnStartStop = 1'b1; tick(9);
        btnStartStop = 1'b0; tick(15);
        nChecks++;
        if (w_outs !== 3'b010) begin
            nFails++;
            $display("FAIL bounce_rejected: got %b expected 010", w_outs);
        end
        btnStartStop = 1'b1; tick(10);
        btnStartStop = 1'b0; tick(2);
        nChecks++;
        if (w_outs !== 3'b010) begin
            nFails++;
            $display("FAIL bounce_accept_edge11: got %b expected 010", w_outs);
        end
        tick();
        nChecks++;
        if (w_outs !== 3'b001) begin
            nFails++;
            $display("FAIL bounce_accept_paused: got %b expected 001", w_outs);
        end
        tick(15);
    endtask

    task automatic test_start_pause_resume();
        logic [2:0] expSeq [3];
        expSeq[0] = 3'b010;
        expSeq[1] = 3'b001;
        expSeq[2] = 3'b010;
        btnClear = 1'b1;
        tick(12);
        nChecks++;
        if (w_outs !== 3'b001) begin
            nFails++;
            $display("FAIL clear_edge11: got %b expected 001", w_outs);
        end
        tick();
        nChecks++;
        if (w_outs !== 3'b100) begin
            nFails++;
            $display("FAIL clear_edge12: got %b expected 100", w_outs);
        end
        tick();
        nChecks++;
        if (w_outs !== 3'b000) begin
            nFails++;
            $display("FAIL clear_to_idle: got %b expected 000", w_outs);
        end
        tick(6);
        btnClear = 1'b0;
        tick(15);
        nChecks++;
        if (w_outs !== 3'b000) begin
            nFails++;
            $display("FAIL clear_held_no_repeat: got %b expected 000", w_outs);
        end
        for (int p = 0; p < 3; p++) begin
            btnStartStop = 1'b1; tick(13);
            btnStartStop = 1'b0; tick(15);
            nChecks++;
            if (w_outs !== expSeq[p]) begin
                nFails++;
                $display("FAIL spr_press[%0d]: got %b expected %b", p, w_outs, expSeq[p]);
            end
        end
    endtask

    task automatic test_simultaneous();
        btnStartStop = 1'b1;
        btnClear     = 1'b1;
        tick(12);
        nChecks++;
        if (w_outs !== 3'b010) begin
            nFails++;
            $display("FAIL simul_edge11: got %b expected 010", w_outs);
        end
        tick();
        nChecks++;
        if (w_outs !== 3'b100) begin
            nFails++;
            $display("FAIL simul_clear_edge12: got %b expected 100", w_outs);
        end
        tick();
        nChecks++;
        if (w_outs !== 3'b000) begin
            nFails++;
            $display("FAIL simul_idle: got %b expected 000", w_outs);
        end
        tick(6);
        btnStartStop = 1'b0;
        btnClear     = 1'b0;
        tick(15);
        nChecks++;
        if (w_outs !== 3'b000) begin
            nFails++;
            $display("FAIL simul_settled: got %b expected 000", w_outs);
        end
    endtask

    task automatic test_midrun_reset();
        btnStartStop = 1'b1;
        tick(13);
        nChecks++;
        if (w_outs !== 3'b010) begin
            nFails++;
            $display("FAIL midrun_running: got %b expected 010", w_outs);
        end
        resetControl = 1'b1;
        tick();
        nChecks++;
        if (w_outs !== 3'b100) begin
            nFails++;
            $display("FAIL midrun_reset_asserted: got %b expected 100", w_outs);
        end
        tick(2);
        resetControl = 1'b0;
        nChecks++;
        if (w_outs !== 3'b100) begin
            nFails++;
            $display("FAIL midrun_release_cycle: got %b expected 100", w_outs);
        end
        tick();
        nChecks++;
        if (w_outs !== 3'b000) begin
            nFails++;
            $display("FAIL midrun_idle: got %b expected 000", w_outs);
        end
        tick(11);
        nChecks++;
        if (w_outs !== 3'b000) begin
            nFails++;
            $display("FAIL midrun_edge12: got %b expected 000", w_outs);
        end
        tick();
        nChecks++;
        if (w_outs !== 3'b010) begin
            nFails++;
            $display("FAIL midrun_reaccept_edge13: got %b expected 010", w_outs);
        end
        btnStartStop = 1'b0;
        tick(20);
        nChecks++;
        if (w_outs !== 3'b010) begin
            nFails++;
            $display("FAIL midrun_release_no_toggle: got %b expected 010", w_outs);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_bounce();
        test_start_pause_resume();
        test_simultaneous();
        test_midrun_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
